// File: rtl/cost_volume_gen.sv
// Absolute-difference cost volume generator: joins left/right pixel
// streams and emits |L(x) - R(x-d)| for every disparity d of each left pixel.
module cost_volume_gen #(
  parameter int MAX_DISP              = 64,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int AXIS_TDATA_WIDTH      = 32,
  parameter int DATA_WIDTH            = 8
) (
  input  logic aclk,
  input  logic areset,

  output logic                        s_axis_l_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_l_tdata,
  input  logic                        s_axis_l_tvalid,
  input  logic                        s_axis_l_tlast,
  input  logic                        s_axis_l_tuser,

  output logic                        s_axis_r_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_r_tdata,
  input  logic                        s_axis_r_tvalid,
  input  logic                        s_axis_r_tlast,
  input  logic                        s_axis_r_tuser,

  input  logic m_axis_costs_tready,
  output logic m_axis_costs_tvalid,
  output logic [MAX_DISP-1:0][DATA_WIDTH-1:0]
               m_axis_costs_tdata [MAX_SAMPLES_PER_CLOCK-1:0],
  output logic m_axis_costs_tlast,
  output logic m_axis_costs_tuser,

  output logic err_sync
);

  localparam int N  = MAX_SAMPLES_PER_CLOCK;
  localparam int DW = DATA_WIDTH;
  localparam int HL = MAX_DISP - 1;
  localparam int CW = $clog2(MAX_DISP + N + 1);

  localparam logic [CW-1:0] COL_MAX = CW'(MAX_DISP);
  localparam logic [CW-1:0] STEP    = CW'(N);

  typedef logic [N-1:0][DW-1:0]        beat_t;
  typedef logic [HL-1:0][DW-1:0]       hist_t;
  typedef logic [MAX_DISP-1:0][DW-1:0] lane_t;

  logic en;
  logic acc;
  logic mismatch;

  beat_t l_pix;
  beat_t r_pix;
  beat_t r_rev;

  hist_t                    hist;
  logic [HL+N-1:0][DW-1:0]  hist_ext;

  logic [CW-1:0] col;
  logic [CW-1:0] beat_col;
  logic [CW-1:0] col_inc;
  logic [CW-1:0] col_next;

  logic          s1_valid;
  beat_t         s1_l;
  beat_t         s1_r;
  hist_t         s1_hist;
  logic [CW-1:0] s1_col;
  logic          s1_last;
  logic          s1_user;

  wire lane_t cost [N-1:0];

  assign en = !areset
           && (m_axis_costs_tready || !m_axis_costs_tvalid);

  assign s_axis_l_tready = en && s_axis_r_tvalid;
  assign s_axis_r_tready = en && s_axis_l_tvalid;

  assign acc = en && s_axis_l_tvalid && s_axis_r_tvalid;

  assign mismatch = (s_axis_l_tlast != s_axis_r_tlast)
                 || (s_axis_l_tuser != s_axis_r_tuser);

  assign l_pix = s_axis_l_tdata[N*DW-1:0];
  assign r_pix = s_axis_r_tdata[N*DW-1:0];

  // History is newest-first: entry 0 is the pixel just left of the beat.
  for (genvar j = 0; j < N; j++) begin : g_rev
    assign r_rev[j] = r_pix[N-1-j];
  end

  assign hist_ext = {hist, r_rev};

  assign beat_col = s_axis_l_tuser ? '0 : col;
  assign col_inc  = beat_col + STEP;

  always_comb begin
    col_next = col_inc;
    if (col_inc > COL_MAX) col_next = COL_MAX;
    if (s_axis_l_tlast)    col_next = '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      col      <= '0;
      hist     <= '0;
      err_sync <= 1'b0;
    end else if (acc) begin
      col  <= col_next;
      hist <= hist_ext[HL-1:0];
      if (mismatch) err_sync <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_l     <= '0;
      s1_r     <= '0;
      s1_hist  <= '0;
      s1_col   <= '0;
      s1_last  <= 1'b0;
      s1_user  <= 1'b0;
    end else if (en) begin
      s1_valid <= acc;
      if (acc) begin
        s1_l    <= l_pix;
        s1_r    <= r_pix;
        s1_hist <= hist;
        s1_col  <= beat_col;
        s1_last <= s_axis_l_tlast;
        s1_user <= s_axis_l_tuser;
      end
    end
  end

  // Lanes reaching past the line start read stale history; mask them.
  for (genvar i = 0; i < N; i++) begin : g_smp
    for (genvar d = 0; d < MAX_DISP; d++) begin : g_dsp
      localparam logic [CW-1:0] DP = CW'(d);
      localparam logic [CW-1:0] IP = CW'(i);

      logic [DW-1:0] rsel;
      logic [DW:0]   diff;
      logic [DW:0]   ndiff;
      logic          ok;

      if (d <= i) begin : g_cur
        assign rsel = s1_r[i-d];
      end else begin : g_hst
        assign rsel = s1_hist[d-i-1];
      end

      assign diff  = {1'b0, s1_l[i]} - {1'b0, rsel};
      assign ndiff = -diff;
      assign ok    = DP <= (s1_col + IP);

      assign cost[i][d] = !ok     ? '1
                        : diff[DW] ? ndiff[DW-1:0]
                        : diff[DW-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_costs_tvalid <= 1'b0;
      m_axis_costs_tdata  <= '{default: '0};
      m_axis_costs_tlast  <= 1'b0;
      m_axis_costs_tuser  <= 1'b0;
    end else if (en) begin
      m_axis_costs_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_costs_tdata <= cost;
        m_axis_costs_tlast <= s1_last;
        m_axis_costs_tuser <= s1_user;
      end
    end
  end

endmodule

// File: tb/tb_cost_volume_gen.sv
// Scoreboard bench for cost_volume_gen: a line-buffer reference model
// predicts every cost beat; a monitor compares what the DUT emits.
module tb_cost_volume_gen;

  localparam int MD = 64;
  localparam int N  = 4;
  localparam int DW = 8;

  typedef logic [N-1:0][MD-1:0][DW-1:0] costs_t;
  typedef struct packed {
    logic   last;
    logic   user;
    costs_t c;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  logic l_tready, r_tready;
  logic [31:0] l_data, r_data;
  logic l_valid, l_last, l_user;
  logic r_valid, r_last, r_user;
  logic m_ready, m_valid, m_last, m_user;
  logic [MD-1:0][DW-1:0] m_tdata [N-1:0];
  logic err;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   xpos  = 0;
  int   rline [4096];
  int   nout, nlast, nuser;
  int   rmode = 0;
  int   pat_idx = 0;
  int   pat [14] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  costs_t got, held;
  logic   held_v = 1'b0;
  logic   held_l, held_u;

  always #5 aclk = ~aclk;

  cost_volume_gen dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_l_tready     (l_tready),
    .s_axis_l_tdata      (l_data),
    .s_axis_l_tvalid     (l_valid),
    .s_axis_l_tlast      (l_last),
    .s_axis_l_tuser      (l_user),
    .s_axis_r_tready     (r_tready),
    .s_axis_r_tdata      (r_data),
    .s_axis_r_tvalid     (r_valid),
    .s_axis_r_tlast      (r_last),
    .s_axis_r_tuser      (r_user),
    .m_axis_costs_tready (m_ready),
    .m_axis_costs_tvalid (m_valid),
    .m_axis_costs_tdata  (m_tdata),
    .m_axis_costs_tlast  (m_last),
    .m_axis_costs_tuser  (m_user),
    .err_sync            (err)
  );

  // Reference: whole-line right buffer indexed by true pixel column.
  function automatic void model_push(input logic [31:0] l,
                                     input logic [31:0] r,
                                     input logic ll, input logic lu);
    exp_t e;
    int x, lv, rv;
    if (lu) xpos = 0;
    for (int i = 0; i < N; i++) rline[xpos+i] = int'(r[8*i +: 8]);
    for (int i = 0; i < N; i++) begin
      x  = xpos + i;
      lv = int'(l[8*i +: 8]);
      for (int d = 0; d < MD; d++) begin
        if (d <= x) begin
          rv = rline[x-d];
          e.c[i][d] = 8'(lv > rv ? lv - rv : rv - lv);
        end else begin
          e.c[i][d] = 8'hFF;
        end
      end
    end
    e.last = ll;
    e.user = lu;
    q.push_back(e);
    xpos = ll ? 0 : xpos + N;
  endfunction

  task automatic chk(input string nm, input logic [63:0] g,
                     input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  task automatic check_beat();
    exp_t e;
    int fi, fd;
    nout++;
    if (m_last) nlast++;
    if (m_user) nuser++;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_beat out=%0d", nout);
      return;
    end
    e  = q.pop_front();
    fi = -1;
    fd = -1;
    for (int i = 0; i < N; i++)
      for (int d = 0; d < MD; d++)
        if (fi < 0 && got[i][d] !== e.c[i][d]) begin
          fi = i;
          fd = d;
        end
    if (fi >= 0 || m_last !== e.last || m_user !== e.user) begin
      bad++;
      if (fi < 0) begin
        fi = 0;
        fd = 0;
      end
      $display("FAIL beat%0d cost[%0d][%0d] got=%0d exp=%0d last got=%b exp=%b user got=%b exp=%b",
               nout, fi, fd, got[fi][fd], e.c[fi][fd],
               m_last, e.last, m_user, e.user);
    end
  endtask

  always @(negedge aclk) begin
    for (int i = 0; i < N; i++) got[i] = m_tdata[i];
    if (areset) begin
      held_v = 1'b0;
    end else begin
      if (m_valid && held_v) begin
        total++;
        if (got !== held || m_last !== held_l || m_user !== held_u) begin
          bad++;
          $display("FAIL stall_hold got_last=%b exp_last=%b data_changed=%b",
                   m_last, held_l, got !== held);
        end
      end
      if (m_valid && m_ready) begin
        check_beat();
        held_v = 1'b0;
      end else if (m_valid) begin
        held_v = 1'b1;
        held   = got;
        held_l = m_last;
        held_u = m_user;
        total++;
        if (l_tready !== 1'b0 || r_tready !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready got=%b%b exp=00", l_tready, r_tready);
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    case (rmode)
      1: m_ready = 1'($urandom_range(0, 1));
      2: begin
        if (pat_idx < 14) begin
          m_ready = 1'(pat[pat_idx]);
          pat_idx++;
        end else begin
          m_ready = 1'b1;
        end
      end
      default: m_ready = 1'b1;
    endcase
  end

  task automatic send_beat(input logic [31:0] l, input logic [31:0] r,
                           input logic ll, input logic lu,
                           input logic rl, input logic ru);
    int w;
    l_data  = l;
    r_data  = r;
    l_last  = ll;
    l_user  = lu;
    r_last  = rl;
    r_user  = ru;
    l_valid = 1'b1;
    r_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge aclk);
      if (l_tready === 1'b1) break;
      w++;
      if (w > 300) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got=0 exp=1");
        break;
      end
    end
    if (w <= 300) model_push(l, r, ll, lu);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    l_valid = 1'b0;
    r_valid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    int c;
    idle(1);
    rmode = 0;
    c = 0;
    while (q.size() > 0 && c < 1000) begin
      @(posedge aclk);
      #1;
      c++;
    end
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] lw, rw;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset  = 1'b1;
    l_valid = 1'b0;
    r_valid = 1'b0;
    l_data  = '0;
    r_data  = '0;
    l_last  = 1'b0;
    l_user  = 1'b0;
    r_last  = 1'b0;
    r_user  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_tdata", 64'(|got), 64'd0);
    chk("rst_last_user", {62'd0, m_last, m_user}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    areset = 1'b0;
    idle(1);

    // Flat images: one 128-pixel line.
    nout = 0; nlast = 0; nuser = 0;
    for (int b = 0; b < 32; b++)
      send_beat({4{8'd100}}, {4{8'd90}}, b == 31, b == 0, b == 31, b == 0);
    drain();
    chk("flat_beats", 64'(nout), 64'd32);
    chk("flat_tlast", 64'(nlast), 64'd1);
    chk("flat_tuser", 64'(nuser), 64'd1);

    // Shifted ramp, 3 lines.
    for (int ln = 0; ln < 3; ln++)
      for (int b = 0; b < 32; b++) begin
        for (int i = 0; i < N; i++) begin
          rw[8*i +: 8] = 8'(4*b + i);
          lw[8*i +: 8] = 8'(4*b + i - 5);
        end
        send_beat(lw, rw, b == 31, ln == 0 && b == 0, b == 31,
                  ln == 0 && b == 0);
      end
    drain();

    // Backpressure pattern while streaming.
    pat_idx = 0;
    rmode   = 2;
    for (int b = 0; b < 16; b++)
      send_beat($urandom, $urandom, b == 15, b == 0, b == 15, b == 0);
    drain();

    // Join: left waits for right.
    lw = $urandom;
    rw = $urandom;
    l_data = lw; r_data = rw;
    l_last = 1'b0; l_user = 1'b1;
    r_last = 1'b0; r_user = 1'b1;
    l_valid = 1'b1;
    r_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("join_l_tready", 64'(l_tready), 64'd0);
      chk("join_no_out", 64'(m_valid), 64'd0);
      @(posedge aclk);
      #1;
    end
    r_valid = 1'b1;
    model_push(lw, rw, 1'b0, 1'b1);
    @(posedge aclk);
    #1;
    l_valid = 1'b0;
    r_valid = 1'b0;
    chk("join_lat1", 64'(m_valid), 64'd0);
    @(posedge aclk);
    #1;
    chk("join_lat2", 64'(m_valid), 64'd1);
    send_beat($urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Short line followed by a new line.
    for (int b = 0; b < 6; b++)
      send_beat($urandom, $urandom, b == 1 || b == 5, b == 0,
                b == 1 || b == 5, b == 0);
    drain();

    // Sideband mismatch.
    chk("err_before", 64'(err), 64'd0);
    send_beat($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_set", 64'(err), 64'd1);
    idle(3);
    chk("err_sticky", 64'(err), 64'd1);
    drain();

    // Reset during beat 5.
    for (int b = 0; b < 5; b++)
      send_beat($urandom, $urandom, 1'b0, b == 0, 1'b0, b == 0);
    l_data = $urandom;
    r_data = $urandom;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    q.delete();
    xpos = 0;
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    areset = 1'b0;
    idle(1);
    for (int b = 0; b < 8; b++)
      send_beat($urandom, $urandom, b == 7, 1'b0, b == 7, 1'b0);
    drain();

    // Random lines, random gaps and random downstream ready.
    rmode = 1;
    for (int ln = 0; ln < 6; ln++) begin
      int nb;
      nb = $urandom_range(1, 32);
      for (int b = 0; b < nb; b++) begin
        send_beat($urandom, $urandom, b == nb - 1, ln == 0 && b == 0,
                  b == nb - 1, ln == 0 && b == 0);
        if ($urandom_range(0, 3) == 0) begin
          idle($urandom_range(1, 3));
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
